// File: rtl/hilo_acc.sv
// HI/LO architectural register pair with single-edge writes and a two-stage
// 2*DW-bit accumulate/deaccumulate. The low half settles first, the high half follows.
module hilo_acc #(
    parameter int DW     = 32,
    parameter int ACC_EN = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          op_valid,
    input  logic [2:0]    op,
    input  logic [DW-1:0] hi_in,
    input  logic [DW-1:0] lo_in,
    output logic          op_ready,
    output logic          done,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC1 = 1'b1
    } state_t;

    localparam logic [2:0] OP_WR_HI   = 3'd1;
    localparam logic [2:0] OP_WR_LO   = 3'd2;
    localparam logic [2:0] OP_WR_BOTH = 3'd3;
    localparam logic [2:0] OP_ADD     = 3'd4;
    localparam logic [2:0] OP_SUB     = 3'd5;
    localparam logic       ACC_ON     = (ACC_EN != 0);

    state_t        state_q, state_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic          done_q, done_d;
    logic [DW-1:0] hi_cap_q, hi_cap_d;
    logic [DW-1:0] lo_sum_q, lo_sum_d;
    logic          carry_q, carry_d;

    logic          accept_s;
    logic          is_sub_s;
    logic [DW-1:0] lo_opnd_s;
    logic [DW:0]   lo_add_s;
    logic [DW-1:0] hi_commit_s;

    assign op_ready = (state_q == IDLE);
    assign accept_s = op_valid & op_ready & ~flush;
    assign done     = done_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

    // Subtraction is addition of the one's complement plus an injected carry-in.
    assign is_sub_s    = (op == OP_SUB);
    assign lo_opnd_s   = is_sub_s ? ~lo_in : lo_in;
    assign lo_add_s    = {1'b0, lo_q} + {1'b0, lo_opnd_s} + {{DW{1'b0}}, is_sub_s};
    assign hi_commit_s = hi_q + hi_cap_q + {{(DW-1){1'b0}}, carry_q};

    // State and architectural register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            hi_q     <= {DW{1'b0}};
            lo_q     <= {DW{1'b0}};
            done_q   <= 1'b0;
            hi_cap_q <= {DW{1'b0}};
            lo_sum_q <= {DW{1'b0}};
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            hi_cap_q <= hi_cap_d;
            lo_sum_q <= lo_sum_d;
            carry_q  <= carry_d;
        end
    end

    // Next-state, write decode and accumulate sequencing.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        hi_cap_d = hi_cap_q;
        lo_sum_d = lo_sum_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    case (op)
                        OP_WR_HI:   hi_d = hi_in;
                        OP_WR_LO:   lo_d = lo_in;
                        OP_WR_BOTH: begin
                            hi_d = hi_in;
                            lo_d = lo_in;
                        end
                        OP_ADD, OP_SUB: begin
                            if (ACC_ON) begin
                                // High operand is stored pre-inverted for SUB so stage 2 is a plain add.
                                state_d  = ACC1;
                                hi_cap_d = is_sub_s ? ~hi_in : hi_in;
                                lo_sum_d = lo_add_s[DW-1:0];
                                carry_d  = lo_add_s[DW];
                            end else begin
                                state_d = IDLE;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            ACC1: begin
                state_d  = IDLE;
                hi_cap_d = {DW{1'b0}};
                lo_sum_d = {DW{1'b0}};
                carry_d  = 1'b0;
                if (!flush) begin
                    hi_d   = hi_commit_s;
                    lo_d   = lo_sum_q;
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hilo_acc.sv
// Directed vector table, hand sequences and randomized run for hilo_acc,
// checked against a 2*DW-bit arithmetic reference model.
module tb_hilo_acc;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        op_ready, done;
    logic [31:0] hi_o, lo_o;
    logic        op_ready0, done0;
    logic [31:0] hi_o0, lo_o0;

    int checks   = 0;
    int failures = 0;

    hilo_acc #(.DW(32), .ACC_EN(1)) u_dut (
        .clk(clk), .resetn(resetn), .flush(flush), .op_valid(op_valid), .op(op),
        .hi_in(hi_in), .lo_in(lo_in), .op_ready(op_ready), .done(done),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    hilo_acc #(.DW(32), .ACC_EN(0)) u_dut_noacc (
        .clk(clk), .resetn(resetn), .flush(flush), .op_valid(op_valid), .op(op),
        .hi_in(hi_in), .lo_in(lo_in), .op_ready(op_ready0), .done(done0),
        .hi_o(hi_o0), .lo_o(lo_o0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Reference model: whole 64-bit accumulator, pending result committed one edge later
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    logic        m_busy = 1'b0, m_done = 1'b0;

    task automatic model_edge();
        logic [63:0] acc;
        acc = {m_hi, m_lo};
        if (!resetn) begin
            m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_busy) begin
            m_busy = 1'b0;
            m_done = !flush;
            if (!flush) {m_hi, m_lo} = m_pend;
        end else begin
            m_done = 1'b0;
            if (op_valid && !flush) begin
                case (op)
                    3'd1: m_hi = hi_in;
                    3'd2: m_lo = lo_in;
                    3'd3: begin m_hi = hi_in; m_lo = lo_in; end
                    3'd4: begin m_pend = acc + {hi_in, lo_in}; m_busy = 1'b1; end
                    3'd5: begin m_pend = acc - {hi_in, lo_in}; m_busy = 1'b1; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_hi", hi_o, m_hi);
        chk("model_lo", lo_o, m_lo);
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_ready", 32'(op_ready), 32'(!m_busy));
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] o, input logic f,
                         input logic [31:0] h, input logic [31:0] l);
        resetn = r; op_valid = v; op = o; flush = f; hi_in = h; lo_in = l;
    endtask

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [2:0]  o;
        logic        f;
        logic [31:0] h;
        logic [31:0] l;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_done;
        logic        e_rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [2:0] o, logic f, logic [31:0] h,
                                logic [31:0] l, logic [31:0] eh, logic [31:0] el,
                                logic ed, logic er);
        vec_t t;
        t.rst_n = r; t.v = v; t.o = o; t.f = f; t.h = h; t.l = l;
        t.e_hi = eh; t.e_lo = el; t.e_done = ed; t.e_rdy = er;
        return t;
    endfunction

    initial begin
        drive(1'b0, 1'b1, 3'd3, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555);

        // Reset held with WR_BOTH pending, then writes, carry, back-to-back ADD, borrow, flush, reset mid-op
        tbl.push_back(mk(1'b0, 1'b1, 3'd3, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 3'd3, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd1, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd2, 1'b0, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd3, 1'b0, 32'h1, 32'h2, 32'h1, 32'h2, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd3, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd4, 1'b0, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 3'd4, 1'b0, 32'h0, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd4, 1'b0, 32'h0, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h1, 32'h1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd3, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd5, 1'b0, 32'h0, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd4, 1'b0, 32'h0, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd3, 1'b1, 32'h7, 32'h7, 32'h0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd3, 1'b0, 32'h3, 32'h4, 32'h3, 32'h4, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd4, 1'b0, 32'h1, 32'h1, 32'h3, 32'h4, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd3, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd4, 1'b0, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h1, 32'h0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd2, 1'b0, 32'h0, 32'h9, 32'h1, 32'h9, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd6, 1'b0, 32'h5, 32'h5, 32'h1, 32'h9, 1'b0, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].v, tbl[i].o, tbl[i].f, tbl[i].h, tbl[i].l);
            tick();
            chk($sformatf("vec%0d_hi", i), hi_o, tbl[i].e_hi);
            chk($sformatf("vec%0d_lo", i), lo_o, tbl[i].e_lo);
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("vec%0d_ready", i), 32'(op_ready), 32'(tbl[i].e_rdy));
        end

        // ACC_EN=0 instance: ADD accepted as NOP, no state change, never busy
        drive(1'b1, 1'b1, 3'd3, 1'b0, 32'h10, 32'h20);
        tick();
        chk("noacc_wr_hi", hi_o0, 32'h10);
        chk("noacc_wr_lo", lo_o0, 32'h20);
        drive(1'b1, 1'b1, 3'd4, 1'b0, 32'h1, 32'h1);
        tick();
        chk("noacc_add_hi", hi_o0, 32'h10);
        chk("noacc_add_lo", lo_o0, 32'h20);
        chk("noacc_add_ready", 32'(op_ready0), 32'd1);
        drive(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("noacc_after_hi", hi_o0, 32'h10);
        chk("noacc_after_lo", lo_o0, 32'h20);
        chk("noacc_after_done", 32'(done0), 32'd0);
        chk("noacc_after_ready", 32'(op_ready0), 32'd1);

        // Randomized traffic including boundary operands, flush and occasional reset
        for (int n = 0; n < 600; n++) begin
            logic [31:0] h, l;
            h = $urandom();
            l = $urandom();
            case ($urandom_range(0, 5))
                0: h = 32'h0;
                1: h = 32'hFFFF_FFFF;
                2: l = 32'h0;
                3: l = 32'hFFFF_FFFF;
                default: ;
            endcase
            drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), h, l);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_acc.md
# hilo_acc

Parametrised HI/LO register block for the CPU execute/writeback path, replacing the fixed 32-bit, single-enable HI/LO pair. It supports independent HI or LO writes (MTHI/MTLO) and paired writes (MULT/DIV results). It also supports a two-cycle pipelined 2·DW-bit accumulate/deaccumulate (MADD/MSUB style) with a ready/done handshake and pipeline flush.

## Interface

Parameters:
- DW, 32: width of each of HI and LO.
- ACC_EN, 1: 1 enables ADD/SUB ops; 0 makes ADD/SUB behave as NOP (accepted, no state change, no done).

Ports:
- clk  in  1  clock; all state updates on the posedge.
- resetn  in  1  reset; synchronous, active-low.
- flush  in  1  pipeline flush; aborts any in-flight accumulate and blocks acceptance this cycle.
- op_valid  in  1  operation request.
- op  in  3  opcode: 0 NOP, 1 WR_HI, 2 WR_LO, 3 WR_BOTH, 4 ADD, 5 SUB; 6–7 are NOP.
- hi_in  in  DW  HI operand / write data.
- lo_in  in  DW  LO operand / write data.
- op_ready  out  1  block can accept an op this cycle.
- done  out  1  one-cycle pulse: accumulate result committed.
- hi_o  out  DW  architectural HI, registered.
- lo_o  out  DW  architectural LO, registered.

## Operation

- Accept condition: op_valid & op_ready & ~flush, sampled at posedge.
- op_ready = 1 in IDLE, 0 in ACC1. Combinational from state only, not from inputs.
- States:
  - IDLE: writes and NOP complete in one edge. An accepted ADD/SUB with ACC_EN=1 goes to ACC1.
  - ACC1: unconditionally returns to IDLE on the next edge, either committing or aborting.
- WR_HI: hi_o <= hi_in; lo_o unchanged.
- WR_LO: lo_o <= lo_in; hi_o unchanged.
- WR_BOTH: both updated on the same edge.
- ADD, stage 1 (accept edge):
  - Capture hi_in into an operand register.
  - Compute lo_sum = {1'b0,lo_o} + {1'b0,lo_in} (DW+1 bits); store low DW bits and carry.
  - hi_o/lo_o are not yet modified.
- ADD, stage 2 (ACC1 edge): hi_o <= hi_o + hi_cap + carry; lo_o <= stored lo_sum. Both update on this same edge.
- SUB: identical structure, implemented as {hi,lo} − {hi_in,lo_in} in two's complement. Stage 1 computes lo_o + ~lo_in + 1 with carry-out; stage 2 computes hi_o + ~hi_cap + carry.
- Arithmetic is modulo 2^(2·DW): no overflow flag, no saturation. Signed and unsigned results are identical bitwise.
- done is registered: high for exactly the one cycle following a committing ACC1 edge.
- flush in ACC1:
  - Next edge returns to IDLE with hi_o/lo_o unchanged and stage-1 temporaries discarded.
  - done stays 0.
- flush in IDLE: op not accepted; state unchanged.
- flush and op_valid together: flush wins.
- While in ACC1, op_valid is ignored (op_ready=0). The requester must hold the op until accepted.
- resetn low: overrides everything, including an in-flight ACC1 and flush.

## Timing

- Reset values (edge with resetn=0): hi_o=0, lo_o=0, done=0, state=IDLE (op_ready=1 on the following cycle), temporaries=0.
- Write latency: accepted at edge N; new value visible on hi_o/lo_o after edge N.
- Accumulate latency: accepted at edge N; result visible after edge N+1; done high during cycle N+1..N+2.
- Accumulate throughput: one per 2 cycles. A new op may be accepted on edge N+2.
- A write accepted at edge N+2 sees the committed accumulate result as the old value for the half it does not write.
- No combinational path from any input to hi_o, lo_o, or done.

## Test plan

- Reset: drive resetn=0 for 2 cycles with op_valid=1, op=WR_BOTH → hi_o=0, lo_o=0, done=0; op_ready=1 after release.
- Writes: WR_HI 0xDEADBEEF, then WR_LO 0x12345678 → after the first edge hi=0xDEADBEEF, lo=0; after the second edge lo=0x12345678, hi unchanged. WR_BOTH 0x1/0x2 → both update on the same edge.
- ADD carry: hi/lo=0x00000000/0xFFFFFFFF, ADD hi_in=0, lo_in=1 → op_ready=0 for one cycle; then hi=0x00000001, lo=0x00000000, done pulses once. Back-to-back ADD held valid is accepted on edge N+2.
- SUB borrow/wrap: hi/lo=0/0, SUB 0/1 → hi=0xFFFFFFFF, lo=0xFFFFFFFF. Then SUB 0xFFFFFFFF/0xFFFFFFFF → 0/0.
- Flush: ADD 0/5 accepted, flush=1 in ACC1 → hi/lo unchanged, done=0, op_ready=1 next cycle. Flush together with op_valid in IDLE → no change.
- Reset mid-op and ACC_EN=0: resetn=0 during ACC1 → hi/lo=0, done=0, IDLE. With ACC_EN=0, ADD 1/1 → accepted, no change, done=0, op_ready stays 1.
